// File: rtl/register_file_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
// Imported by the storage/read-mux top and by the pending scoreboard.
package register_file_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/register_file_sb_reg_scoreboard.sv
// Per-register pending bits plus a running count of pending registers.
// A same-cycle issue and write to one register leaves it pending: the newer producer owns it.
module reg_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_issue,
    input  logic [AW-1:0]   i_addr_issue,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr_write,
    output logic [NREG-1:0] o_pend,
    output logic [AW:0]     o_pending_count
);

    logic [NREG-1:0] r_pend;
    logic [AW:0]     r_count;

    logic            w_set_en;
    logic            w_clr_en;
    logic            w_new_set;
    logic            w_real_clr;
    logic [NREG-1:0] w_pend_next;
    logic [AW:0]     w_count_next;

    always_comb begin
        w_set_en = i_issue && !((ZERO_REG != 0) && (i_addr_issue == AW'(REG_ZERO)));
        w_clr_en = i_we && !((ZERO_REG != 0) && (i_addr_write == AW'(REG_ZERO)))
                   && !(w_set_en && (i_addr_write == i_addr_issue));
        // Only transitions of a bit move the count, so it can neither overflow nor underflow.
        w_new_set  = w_set_en && !r_pend[i_addr_issue];
        w_real_clr = w_clr_en && r_pend[i_addr_write];

        w_pend_next = r_pend;
        if (w_clr_en) w_pend_next[i_addr_write] = 1'b0;
        if (w_set_en) w_pend_next[i_addr_issue] = 1'b1;

        w_count_next = r_count;
        if (w_new_set && !w_real_clr)
            w_count_next = r_count + (AW+1)'(1);
        else if (!w_new_set && w_real_clr)
            w_count_next = r_count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_count <= '0;
        end else begin
            r_pend  <= w_pend_next;
            r_count <= w_count_next;
        end
    end

    assign o_pend          = r_pend;
    assign o_pending_count = r_count;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with one synchronous write port, optional write-through
// bypass on the combinational reads, and a pending scoreboard for in-flight producers.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            addr_write,
    input  logic [XLEN-1:0]          data_write,
    input  logic [NUM_READ*AW-1:0]   addr_read,
    output logic [NUM_READ*XLEN-1:0] data_read,
    output logic [NUM_READ-1:0]      pend_read,
    input  logic                     issue,
    input  logic [AW-1:0]            addr_issue,
    output logic [AW:0]              pending_count,
    output logic                     hazard
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_pend;
    logic            w_wr_ok;

    assign w_wr_ok = we && !((ZERO_REG != 0) && (addr_write == AW'(REG_ZERO)));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[addr_write] <= data_write;
        end
    end

    reg_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .i_issue         (issue),
        .i_addr_issue    (addr_issue),
        .i_we            (we),
        .i_addr_write    (addr_write),
        .o_pend          (w_pend),
        .o_pending_count (pending_count)
    );

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [AW-1:0]   w_raddr;
        logic [XLEN-1:0] w_rdata;

        assign w_raddr = addr_read[g*AW +: AW];

        // Zero-register check comes last so it also masks a bypassed write to r0.
        always_comb begin
            w_rdata = r_regs[w_raddr];
            if ((BYPASS != 0) && we && (addr_write == w_raddr)) w_rdata = data_write;
            if ((ZERO_REG != 0) && (w_raddr == AW'(REG_ZERO))) w_rdata = '0;
        end

        assign data_read[g*XLEN +: XLEN] = w_rdata;
        // Pending comes from registered state only; decode masks it with the bypass match.
        assign pend_read[g] = w_pend[w_raddr];
    end

    assign hazard = |pend_read;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed plus random checks of register_file_sb, one bypassing and one non-bypassing
// instance sharing the same stimulus, against a rule-level register/pending model.
module tb_register_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NR   = 2;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [AW-1:0]   addr_write;
    logic [XLEN-1:0] data_write;
    logic [NR*AW-1:0] addr_read;
    logic            issue;
    logic [AW-1:0]   addr_issue;

    logic [NR*XLEN-1:0] b_data, n_data;
    logic [NR-1:0]      b_pend, n_pend;
    logic [AW:0]        b_count, n_count;
    logic               b_hazard, n_hazard;

    int n_assert = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];

    always #5 clk = ~clk;

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .NUM_READ(NR), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .we(we), .addr_write(addr_write), .data_write(data_write),
        .addr_read(addr_read), .data_read(b_data), .pend_read(b_pend), .issue(issue),
        .addr_issue(addr_issue), .pending_count(b_count), .hazard(b_hazard)
    );

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .NUM_READ(NR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .addr_write(addr_write), .data_write(data_write),
        .addr_read(addr_read), .data_read(n_data), .pend_read(n_pend), .issue(issue),
        .addr_issue(addr_issue), .pending_count(n_count), .hazard(n_hazard)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    // Expected read value: r0 is zero; a same-cycle write is visible only when bypassing.
    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a, input bit bypass);
        if (a == 0) return '0;
        if (bypass && we && addr_write == a) return data_write;
        return m_regs[a];
    endfunction

    task automatic check_all(input string tag);
        logic [AW-1:0] a;
        bit hz = 0;
        for (int k = 0; k < NR; k++) begin
            a = addr_read[k*AW +: AW];
            chk({tag, "_bdata"}, 64'(b_data[k*XLEN +: XLEN]), 64'(model_read(a, 1)));
            chk({tag, "_ndata"}, 64'(n_data[k*XLEN +: XLEN]), 64'(model_read(a, 0)));
            chk({tag, "_bpend"}, 64'(b_pend[k]), 64'(m_pend[a]));
            chk({tag, "_npend"}, 64'(n_pend[k]), 64'(m_pend[a]));
            hz = hz | m_pend[a];
        end
        chk({tag, "_bhaz"}, 64'(b_hazard), 64'(hz));
        chk({tag, "_nhaz"}, 64'(n_hazard), 64'(hz));
        chk({tag, "_bcnt"}, 64'(b_count), 64'(model_count()));
        chk({tag, "_ncnt"}, 64'(n_count), 64'(model_count()));
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && addr_write != 0) begin
                m_regs[addr_write] = data_write;
                m_pend[addr_write] = 1'b0;
            end
            if (issue && addr_issue != 0) m_pend[addr_issue] = 1'b1;
        end
    endtask

    // Inputs are already set (after a falling edge); check, clock, then return after the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; we = 0; issue = 0;
        addr_write = '0; data_write = '0; addr_issue = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        addr_read = {a1, a0};
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = 'x;
            m_pend[i] = 1'b0;
        end
        idle();
        set_rd(0, 0);
        rst = 1;
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 0;

        // Reset state on every address, both ports.
        for (int a = 0; a < NREG; a++) begin
            set_rd(AW'(a), AW'(NREG - 1 - a));
            #1;
            check_all("reset_scan");
            @(negedge clk);
        end
        chk("reset_count", 64'(b_count), 64'd0);

        // Bypass versus non-bypass on r5.
        we = 1; addr_write = 5; data_write = 32'hDEADBEEF; set_rd(5, 1);
        #1;
        chk("bypass_same_cycle", 64'(b_data[XLEN-1:0]), 64'h0000_0000_DEAD_BEEF);
        chk("nobypass_same_cycle", 64'(n_data[XLEN-1:0]), 64'd0);
        cycle("wr_r5");
        idle(); set_rd(5, 5);
        #1;
        chk("nobypass_next_cycle", 64'(n_data[XLEN-1:0]), 64'h0000_0000_DEAD_BEEF);
        cycle("rd_r5");

        // Zero register: writes ignored, issue ignored.
        we = 1; addr_write = 0; data_write = 32'h12345678; set_rd(0, 0);
        cycle("wr_r0");
        idle(); issue = 1; addr_issue = 0;
        #1;
        chk("r0_port0", 64'(b_data[XLEN-1:0]), 64'd0);
        chk("r0_port1", 64'(b_data[2*XLEN-1:XLEN]), 64'd0);
        cycle("iss_r0");
        idle();
        #1;
        chk("r0_not_pending", 64'(b_pend[0]), 64'd0);
        chk("r0_count", 64'(b_count), 64'd0);

        // Issue r3, r7, r3 again; then writes to r3 and never-issued r9.
        issue = 1; addr_issue = 3; cycle("iss_r3");
        #1; chk("count_after_r3", 64'(b_count), 64'd1);
        addr_issue = 7; cycle("iss_r7");
        #1; chk("count_after_r7", 64'(b_count), 64'd2);
        addr_issue = 3; cycle("reiss_r3");
        #1; chk("count_reissue", 64'(b_count), 64'd2);
        idle(); we = 1; addr_write = 3; data_write = 32'h0000_0033; cycle("wr_r3");
        idle(); set_rd(3, 7);
        #1;
        chk("count_after_wr_r3", 64'(b_count), 64'd1);
        chk("pend_r3_cleared", 64'(b_pend[0]), 64'd0);
        chk("pend_r7_held", 64'(b_pend[1]), 64'd1);
        chk("hazard_r7", 64'(b_hazard), 64'd1);
        we = 1; addr_write = 9; data_write = 32'h0000_0099; cycle("wr_r9");
        idle();
        #1; chk("count_after_wr_r9", 64'(b_count), 64'd1);

        // Issue and write the same register: set wins, data still lands.
        issue = 1; addr_issue = 4; we = 1; addr_write = 4; data_write = 32'hA5A5A5A5;
        set_rd(4, 7);
        cycle("iss_wr_r4");
        idle(); set_rd(4, 7);
        #1;
        chk("r4_data", 64'(n_data[XLEN-1:0]), 64'h0000_0000_A5A5_A5A5);
        chk("r4_pending", 64'(b_pend[0]), 64'd1);
        chk("r4_count", 64'(b_count), 64'd2);
        cycle("post_r4");

        // Reset overrides a simultaneous issue.
        rst = 1; cycle("rst2");
        idle(); we = 1; addr_write = 2; data_write = 32'h55; cycle("wr_r2");
        idle(); issue = 1; addr_issue = 2; cycle("iss_r2");
        idle();
        #1; chk("r2_count1", 64'(b_count), 64'd1);
        rst = 1; issue = 1; addr_issue = 6; cycle("rst_with_issue");
        idle(); set_rd(2, 6);
        #1;
        chk("rst_count", 64'(b_count), 64'd0);
        chk("rst_r2_data", 64'(b_data[XLEN-1:0]), 64'd0);
        chk("rst_r2_pend", 64'(b_pend[0]), 64'd0);
        chk("rst_r6_pend", 64'(b_pend[1]), 64'd0);
        cycle("post_rst");

        // Random traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            int amax;
            amax = ($urandom_range(1, 0) == 1) ? 7 : NREG - 1;
            rst        = ($urandom_range(59, 0) == 0);
            we         = ($urandom_range(1, 0) == 1);
            issue      = ($urandom_range(2, 0) != 0);
            addr_write = AW'($urandom_range(amax, 0));
            addr_issue = AW'($urandom_range(amax, 0));
            data_write = $urandom;
            set_rd(AW'($urandom_range(amax, 0)), AW'($urandom_range(amax, 0)));
            cycle("rand");
        end
        idle();
        #1;
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file.
- Provides NUM_READ combinational read ports and one synchronous write port, with optional write-through bypass.
- Adds a per-register pending scoreboard so a multi-cycle datapath (load/mul units) can mark destinations in flight and detect RAW hazards.
- Sits between decode (read/issue) and writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, ≥ 2.
- NUM_READ, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return the old value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending.
- AW, $clog2(NREG), address width; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- addr_write  in  AW  write address.
- data_write  in  XLEN  write data.
- addr_read  in  NUM_READ*AW  read addresses; port k uses bits [k*AW +: AW].
- data_read  out  NUM_READ*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- pend_read  out  NUM_READ  pending bit of each read address.
- issue  in  1  mark addr_issue as pending (producer dispatched).
- addr_issue  in  AW  destination being issued.
- pending_count  out  AW+1  number of registers currently pending.
- hazard  out  1  OR of pend_read.

Behaviour:
- Reset: on a rising edge with rst=1, all registers clear to 0, all pending bits clear, pending_count=0. Reset overrides we and issue in the same cycle.
- Write: when we=1 at a rising edge, regs[addr_write] <= data_write. If ZERO_REG=1 and addr_write=0, the write is ignored.
- Read: data_read[k] is combinational from addr_read[k], with zero latency.
  - ZERO_REG=1 and address 0: data_read[k] returns 0.
  - BYPASS=1, we=1, addr_write==addr_read[k], and the address is not the zero register: data_read[k] returns data_write in the same cycle.
  - BYPASS=0: data_read[k] returns the stored value; the new value is visible from the next cycle.
- Scoreboard, one bit per register:
  - issue=1 sets pend[addr_issue] at the rising edge.
  - we=1 clears pend[addr_write] at the rising edge.
  - issue and we on the same address in the same cycle: set wins (the newer producer owns the register), and the data write still happens.
  - issue and we on different addresses in the same cycle: both take effect.
  - ZERO_REG=1: register 0 is never set and always reads pending=0.
  - Re-issuing an already-pending register leaves it pending; the count is unchanged.
  - A write to a non-pending register leaves the count unchanged.
- pend_read[k] = pend[addr_read[k]], taken from registered state; bypass does not clear it combinationally. With BYPASS=1 the decode stage treats pend_read & ~(we & addr match) as the stall condition.
- pending_count is registered and updated with the same edge as the pend bits, by net change: +1 on a new set, -1 on a clear of a set bit, 0 when both occur or neither changes a bit.
  - Never exceeds NREG (or NREG-1 when ZERO_REG=1). Never underflows.
- hazard = |pend_read, combinational.

Decomposition:
- Shared package: XLEN / NREG defaults, and a REG_ZERO address constant.
- Natural sub-module: reg_scoreboard, holding the pend vector, pending_count and the set-wins rule, parametrised on NREG/ZERO_REG.
- register_file_sb instantiates reg_scoreboard plus the storage array and the read muxes.

Test Plan:
- Reset, then read all addresses on all ports → every data_read=0, pend_read=0, pending_count=0.
- Write 0xDEADBEEF to r5 with BYPASS=1, reading r5 on port0 in the same cycle → data_read0=0xDEADBEEF in that cycle. Repeat with BYPASS=0 → old value 0 that cycle, 0xDEADBEEF the next.
- Write 0x12345678 to r0 with ZERO_REG=1, then read r0 on both ports → 0. Issue r0 → pend_read=0, pending_count stays 0.
- Issue r3, then r7, then r3 again → pending_count 1, 2, 2. Write r3 → pending_count 1 and pend_read(r3)=0. Write r9 (never issued) → count unchanged.
- Issue r4 and write r4=0xA5A5A5A5 in the same cycle → r4 reads 0xA5A5A5A5, pend_read(r4)=1, count +1.
- With r2 pending and count=1, assert rst together with issue r6 → next cycle count=0, all pend bits clear, r2 reads 0.
